// File: rtl/sm_step_scheduler.sv
// Step-pulse sequencer between the tracking controller and the stepper driver pins.
// Guarantees step pulse width, direction setup before a step, and a floor on step period.
module sm_step_scheduler #(
  parameter int PERIOD_W   = 17,
  parameter int POS_W      = 24,
  parameter int PULSE_W    = 50,
  parameter int DIR_SETUP  = 250,
  parameter int MIN_PERIOD = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                dir_req,
  input  logic [PERIOD_W-1:0] period,
  input  logic                pos_clear,
  output logic                drv_step,
  output logic                drv_dir,
  output logic                drv_en,
  output logic                busy,
  output logic [POS_W-1:0]    step_pos
);

  localparam int CNT_W = (PERIOD_W > $clog2(DIR_SETUP + 1)) ? PERIOD_W : $clog2(DIR_SETUP + 1);
  localparam logic [PERIOD_W-1:0] MIN_P    = PERIOD_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]    HI_LAST  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0]    DIR_LAST = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0]    LO_SKIP  = CNT_W'(PULSE_W + 1);

  typedef enum logic [1:0] {IDLE, DIR_WAIT, STEP_HI, STEP_LO} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [PERIOD_W-1:0] p_lat;
  logic [PERIOD_W-1:0] p_eff;
  logic                go;
  logic                lo_last;
  logic                dir_load;
  logic                step_entry;

  assign p_eff = (period < MIN_P) ? MIN_P : period;
  assign go    = enable && (period != '0);
  assign busy  = (state != IDLE);
  // The low phase ends so that the next rise lands p_lat cycles after the previous one.
  assign lo_last = (cnt == (CNT_W'(p_lat) - LO_SKIP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dir_load  = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          if (dir_req != drv_dir) begin
            state_nxt = DIR_WAIT;
            dir_load  = 1'b1;
          end else begin
            state_nxt = STEP_HI;
          end
        end
      end
      DIR_WAIT: begin
        if (!enable)              state_nxt = IDLE;
        else if (cnt == DIR_LAST) state_nxt = STEP_HI;
      end
      STEP_HI: begin
        if (cnt == HI_LAST) state_nxt = enable ? STEP_LO : IDLE;
      end
      STEP_LO: begin
        if (lo_last) begin
          if (!go) begin
            state_nxt = IDLE;
          end else if (dir_req != drv_dir) begin
            state_nxt = DIR_WAIT;
            dir_load  = 1'b1;
          end else begin
            state_nxt = STEP_HI;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    step_entry = (state_nxt == STEP_HI) && (state != STEP_HI);
  end

  // Datapath: cnt restarts on every state change; period and position update only at a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      p_lat    <= '0;
      drv_step <= 1'b0;
      drv_dir  <= 1'b0;
      drv_en   <= 1'b0;
      step_pos <= '0;
    end else begin
      if (state_nxt != state || state == IDLE) cnt <= '0;
      else                                     cnt <= cnt + CNT_W'(1);
      if (dir_load)   drv_dir <= dir_req;
      if (step_entry) p_lat   <= p_eff;
      drv_step <= (state_nxt == STEP_HI);
      drv_en   <= enable | busy;
      if (pos_clear)       step_pos <= '0;
      else if (step_entry) step_pos <= drv_dir ? step_pos + POS_W'(1) : step_pos - POS_W'(1);
    end
  end

endmodule

// File: tb/tb_sm_step_scheduler.sv
// Directed bench for sm_step_scheduler with a scoreboard of expected step rises
// (cycle, position, direction) checked by a monitor on the falling clock edge.
module tb_sm_step_scheduler;

  localparam int PERIOD_W = 17;
  localparam int POS_W    = 24;
  localparam int PULSE_W  = 4;

  logic                clk;
  logic                rst;
  logic                enable;
  logic                dir_req;
  logic [PERIOD_W-1:0] period;
  logic                pos_clear;
  logic                drv_step;
  logic                drv_dir;
  logic                drv_en;
  logic                busy;
  logic [POS_W-1:0]    step_pos;

  typedef struct {
    int   cyc;
    int   pos;
    logic dir;
  } rise_t;

  rise_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  logic  prev_step = 1'b0;
  int    hi_len = 0;

  sm_step_scheduler #(
    .PERIOD_W  (PERIOD_W),
    .POS_W     (POS_W),
    .PULSE_W   (PULSE_W),
    .DIR_SETUP (6),
    .MIN_PERIOD(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .dir_req  (dir_req),
    .period   (period),
    .pos_clear(pos_clear),
    .drv_step (drv_step),
    .drv_dir  (drv_dir),
    .drv_en   (drv_en),
    .busy     (busy),
    .step_pos (step_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic dir, input int per, input logic clr);
    enable    = en;
    dir_req   = dir;
    period    = PERIOD_W'(per);
    pos_clear = clr;
  endtask

  task automatic waitCycle(input int t);
    while (cyc < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expectRise(input int c, input int p, input logic d);
    rise_t r;
    r.cyc = c;
    r.pos = p;
    r.dir = d;
    exp_q.push_back(r);
  endtask

  function automatic logic [31:0] posBits(input int v);
    logic [POS_W-1:0] t;
    t = v[POS_W-1:0];
    return 32'(t);
  endfunction

  // Monitor: every rise must match the head of the scoreboard; every pulse must be PULSE_W wide.
  always @(negedge clk) begin
    if (rst) begin
      prev_step = 1'b0;
      hi_len    = 0;
    end else begin
      if (drv_step && !prev_step) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("[TB] FAIL unexpected_rise observed=cycle %0d expected=no rise", cyc);
        end
        if (exp_q.size() > 0) begin
          rise_t e;
          e = exp_q.pop_front();
          checkOutput("rise_cycle", cyc, e.cyc);
          checkOutput("rise_pos", 32'(step_pos), posBits(e.pos));
          checkOutput("rise_dir", 32'(drv_dir), 32'(e.dir));
        end
      end
      if (drv_step) hi_len++;
      if (prev_step && !drv_step) begin
        checkOutput("pulse_width", hi_len, PULSE_W);
        hi_len = 0;
      end
      prev_step = drv_step;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c, s, r, q;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    waitCycle(3);
    checkOutput("rst_step", 32'(drv_step), 0);
    checkOutput("rst_dir", 32'(drv_dir), 0);
    checkOutput("rst_en", 32'(drv_en), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_pos", 32'(step_pos), 0);
    rst = 1'b0;
    waitCycle(5);
    checkOutput("idle_en", 32'(drv_en), 0);

    // Steady stepping down at period 20, then clamped period, then stop at a boundary.
    c = cyc;
    applyStimulus(1'b1, 1'b0, 20, 1'b0);
    for (int k = 0; k < 5; k++) expectRise(c + 1 + 20 * k, -(k + 1), 1'b0);
    waitCycle(c + 2);
    checkOutput("run_en", 32'(drv_en), 1);
    checkOutput("run_busy", 32'(busy), 1);
    waitCycle(c + 82);
    applyStimulus(1'b1, 1'b0, 3, 1'b0);
    expectRise(c + 101, -6, 1'b0);
    expectRise(c + 111, -7, 1'b0);
    expectRise(c + 121, -8, 1'b0);
    waitCycle(c + 125);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    waitCycle(c + 130);
    checkOutput("stop_busy_before", 32'(busy), 1);
    waitCycle(c + 131);
    checkOutput("stop_busy", 32'(busy), 0);
    checkOutput("stop_step", 32'(drv_step), 0);
    waitCycle(c + 160);
    checkOutput("stop_pos", 32'(step_pos), posBits(-8));
    checkOutput("stop_idle", 32'(busy), 0);

    // Direction change mid-period waits for the boundary plus setup time.
    s = cyc;
    applyStimulus(1'b1, 1'b0, 20, 1'b0);
    expectRise(s + 1, -9, 1'b0);
    waitCycle(s + 5);
    applyStimulus(1'b1, 1'b1, 20, 1'b0);
    waitCycle(s + 20);
    checkOutput("dir_hold", 32'(drv_dir), 0);
    waitCycle(s + 21);
    checkOutput("dir_switch", 32'(drv_dir), 1);
    checkOutput("dir_wait_step", 32'(drv_step), 0);
    checkOutput("dir_wait_busy", 32'(busy), 1);
    expectRise(s + 27, -8, 1'b1);
    expectRise(s + 47, -7, 1'b1);

    // Period change mid-period applies from the following interval.
    waitCycle(s + 50);
    applyStimulus(1'b1, 1'b1, 40, 1'b0);
    expectRise(s + 67, -6, 1'b1);
    expectRise(s + 107, -5, 1'b1);

    // Enable dropped just after a rise: pulse completes, then idle.
    waitCycle(s + 108);
    applyStimulus(1'b0, 1'b1, 40, 1'b0);
    waitCycle(s + 110);
    checkOutput("drop_step_high", 32'(drv_step), 1);
    waitCycle(s + 111);
    checkOutput("drop_step_low", 32'(drv_step), 0);
    checkOutput("drop_busy", 32'(busy), 0);
    checkOutput("drop_en_lag", 32'(drv_en), 1);
    waitCycle(s + 112);
    checkOutput("drop_en_off", 32'(drv_en), 0);

    // Reset mid-pulse, restart, and position clear.
    waitCycle(s + 120);
    r = cyc;
    applyStimulus(1'b1, 1'b1, 20, 1'b0);
    expectRise(r + 1, -4, 1'b1);
    waitCycle(r + 2);
    rst = 1'b1;
    #1;
    checkOutput("midrst_step", 32'(drv_step), 0);
    checkOutput("midrst_dir", 32'(drv_dir), 0);
    checkOutput("midrst_en", 32'(drv_en), 0);
    checkOutput("midrst_pos", 32'(step_pos), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    applyStimulus(1'b1, 1'b0, 20, 1'b0);
    waitCycle(r + 5);
    rst = 1'b0;
    q = cyc;
    expectRise(q + 1, -1, 1'b0);
    expectRise(q + 21, -2, 1'b0);
    waitCycle(q + 40);
    applyStimulus(1'b1, 1'b0, 20, 1'b1);
    expectRise(q + 41, 0, 1'b0);
    waitCycle(q + 41);
    applyStimulus(1'b1, 1'b0, 20, 1'b0);
    expectRise(q + 61, -1, 1'b0);
    waitCycle(q + 70);
    applyStimulus(1'b1, 1'b0, 20, 1'b1);
    waitCycle(q + 71);
    applyStimulus(1'b1, 1'b0, 20, 1'b0);
    checkOutput("clear_pos", 32'(step_pos), 0);
    expectRise(q + 81, -1, 1'b0);
    waitCycle(q + 83);
    applyStimulus(1'b0, 1'b0, 20, 1'b0);
    waitCycle(q + 100);
    checkOutput("final_busy", 32'(busy), 0);
    checkOutput("final_pos", 32'(step_pos), posBits(-1));
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
